// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and
// the bit-period helper used by both the transmitter and the receiver bench.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_e;

  function automatic int unsigned uart_clkcount(input int unsigned clk_freq,
                                                input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-side handshake between a byte producer (master) and uart_tx (slave).
interface uart_tx_if;
  import uart_pkg::*;

  logic                 newd;
  logic [DATA_BITS-1:0] tx_data;
  logic                 busy;
  logic                 done;

  modport master (output newd, output tx_data, input busy, input done);
  modport slave  (input newd, input tx_data, output busy, output done);

endinterface

// File: rtl/uart_baud_tick.sv
// Clock-enable baud tick: counts 0..clkcount-1 while en is high, pulses tick
// on the last count and wraps; held at zero whenever en is low.
module uart_baud_tick #(
  parameter int unsigned clkcount = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned       cw   = $clog2(clkcount);
  localparam logic [cw-1:0]     last = cw'(clkcount - 1);

  logic [cw-1:0] count;

  assign tick = en && (count == last);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      count <= '0;
    end else if (count == last) begin
      count <= '0;
    end else begin
      count <= count + cw'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, one stop bit, with
// bit timing from a clock-enable baud tick on the single system clock.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq  = 1000000,
  parameter int unsigned baud_rate = 9600
) (
  input  logic        clk,
  input  logic        rst,
  uart_tx_if.slave    bus,
  output logic        tx
);

  localparam int unsigned clkcount = uart_clkcount(clk_freq, baud_rate);
  localparam int unsigned iw       = $clog2(DATA_BITS);
  localparam logic [iw-1:0] last_idx = iw'(DATA_BITS - 1);

  if (clkcount < 2) begin : g_bad_clkcount
    $error("uart_tx: clk_freq/baud_rate must be at least 2");
  end

  uart_tx_state_e       state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [iw-1:0]        bit_idx_q, bit_idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tx_q, tx_d;
  logic                 tick;

  uart_baud_tick #(
    .clkcount (clkcount)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .en   (busy_q),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tx_q      <= tx_d;
    end
  end

  // tx is registered from the next state so the line changes on the same
  // edge as the state, keeping every bit exactly clkcount cycles wide.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tx_d      = 1'b1;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.newd) begin
          shreg_d   = bus.tx_data;
          bit_idx_d = '0;
          busy_d    = 1'b1;
          state_d   = START;
          tx_d      = 1'b0;
        end
      end

      START: begin
        tx_d = 1'b0;
        if (tick) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
        end
      end

      DATA: begin
        tx_d = shreg_q[0];
        if (tick) begin
          shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + iw'(1);
          if (bit_idx_q == last_idx) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d = shreg_d[0];
          end
        end
      end

      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at the default 1 MHz / 9600 baud (104 cycles/bit).
module tb_uart_tx;

  localparam int CC   = 104;
  localparam int FR   = 1040;
  localparam int NCAP = 2200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;

  uart_tx_if bus();

  uart_tx #(
    .clk_freq  (1000000),
    .baud_rate (9600)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .tx  (tx)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic tx_s   [NCAP];
  logic busy_s [NCAP];
  logic done_s [NCAP];

  function automatic logic exp_bit(input logic [7:0] d, input int b);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    return fr[b];
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle after accept.
  task automatic start_frame(input logic [7:0] d);
    bus.newd    = 1'b1;
    bus.tx_data = d;
    @(negedge clk);
    bus.newd = 1'b0;
  endtask

  // Records n cycles of outputs; optionally pulses newd or rst after sample i.
  task automatic capture(input int n, input int inj_at, input logic [7:0] inj_d,
                         input int rst_at);
    for (int i = 0; i < n; i++) begin
      tx_s[i]   = tx;
      busy_s[i] = bus.busy;
      done_s[i] = bus.done;
      bus.newd  = (i == inj_at);
      if (i == inj_at) bus.tx_data = inj_d;
      rst = (i == rst_at);
      @(negedge clk);
    end
    bus.newd = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic test_reset;
    bus.newd    = 1'b0;
    bus.tx_data = 8'h00;
    rst         = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tests++;
    if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle;
    int btx, bbusy, bdone;
    btx = 0; bbusy = 0; bdone = 0;
    for (int i = 0; i < 2000; i++) begin
      if (tx !== 1'b1) btx++;
      if (bus.busy !== 1'b0) bbusy++;
      if (bus.done !== 1'b0) bdone++;
      @(negedge clk);
    end
    tests++;
    if (btx != 0) begin fails++; $display("FAIL idle_tx: %0d cycles not 1, want 0", btx); end
    tests++;
    if (bbusy != 0) begin fails++; $display("FAIL idle_busy: %0d cycles not 0, want 0", bbusy); end
    tests++;
    if (bdone != 0) begin fails++; $display("FAIL idle_done: %0d cycles not 0, want 0", bdone); end
  endtask

  task automatic test_frame_55;
    logic [9:0] seq;
    int bad, nd;
    seq = 10'b1010101010;
    start_frame(8'h55);
    capture(FR + 5, -1, 8'h00, -1);
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < CC; c++) if (tx_s[b*CC + c] !== seq[b]) bad++;
      tests++;
      if (bad != 0) begin
        fails++;
        $display("FAIL frame55_bit%0d: %0d cycles wrong, want tx=%b", b, bad, seq[b]);
      end
    end
    nd = 0;
    for (int i = 0; i < FR + 5; i++) if (done_s[i] === 1'b1) nd++;
    tests++;
    if (nd != 1 || done_s[FR] !== 1'b1) begin
      fails++;
      $display("FAIL frame55_done: %0d pulses, at_%0d=%b, want 1 pulse at %0d", nd, FR, done_s[FR], FR);
    end
    bad = 0;
    for (int i = 0; i < FR + 5; i++) if (busy_s[i] !== (i < FR)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL frame55_busy: %0d cycles wrong, want 0", bad); end
    bad = 0;
    for (int i = FR; i < FR + 5; i++) if (tx_s[i] !== 1'b1) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL frame55_idle_tx: %0d cycles low, want 0", bad); end
  endtask

  task automatic test_loopback_a3;
    logic [7:0] rx;
    logic [7:0] bits_lsb_first;
    start_frame(8'hA3);
    capture(FR + 5, -1, 8'h00, -1);
    rx = 8'h00;
    for (int b = 1; b <= 8; b++) rx[b-1] = tx_s[b*CC + CC/2];
    tests++;
    if (rx !== 8'hA3) begin fails++; $display("FAIL a3_decode: got %h want a3", rx); end
    bits_lsb_first = 8'b10100011;
    tests++;
    if (rx !== bits_lsb_first) begin fails++; $display("FAIL a3_bits: got %b want %b", rx, bits_lsb_first); end
    tests++;
    if (tx_s[CC/2] !== 1'b0 || tx_s[9*CC + CC/2] !== 1'b1) begin
      fails++;
      $display("FAIL a3_framing: start=%b stop=%b want 0 1", tx_s[CC/2], tx_s[9*CC + CC/2]);
    end
    tests++;
    if (done_s[FR] !== 1'b1 || done_s[FR-1] !== 1'b0) begin
      fails++;
      $display("FAIL a3_done: at_%0d=%b before=%b want 1 0", FR, done_s[FR], done_s[FR-1]);
    end
  endtask

  task automatic test_ignore_busy;
    int bad, nd;
    start_frame(8'h00);
    capture(FR + 5, 300, 8'hFF, -1);
    bad = 0;
    for (int i = 0; i < FR; i++) if (tx_s[i] !== exp_bit(8'h00, i / CC)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL ignore_frame: %0d cycles wrong, want 0", bad); end
    nd = 0;
    for (int i = 0; i < FR + 5; i++) if (done_s[i] === 1'b1) nd++;
    tests++;
    if (nd != 1 || done_s[FR] !== 1'b1) begin
      fails++;
      $display("FAIL ignore_done: %0d pulses, at_%0d=%b, want 1 pulse", nd, FR, done_s[FR]);
    end
    tests++;
    if (busy_s[301] !== 1'b1) begin fails++; $display("FAIL ignore_busy: got %b want 1", busy_s[301]); end
    bus.tx_data = 8'h00;
  endtask

  task automatic test_back_to_back;
    int d1, d2, bad;
    d1 = -1; d2 = -1;
    bus.newd    = 1'b1;
    bus.tx_data = 8'h01;
    @(negedge clk);
    for (int i = 0; i < NCAP; i++) begin
      tx_s[i]   = tx;
      busy_s[i] = bus.busy;
      done_s[i] = bus.done;
      if (bus.done === 1'b1) begin
        if (d1 < 0) begin
          d1 = i;
          bus.tx_data = 8'h80;
        end else if (d2 < 0) begin
          d2 = i;
          bus.newd = 1'b0;
        end
      end
      @(negedge clk);
    end
    bus.newd = 1'b0;
    tests++;
    if (d1 != FR) begin fails++; $display("FAIL b2b_done1: at %0d want %0d", d1, FR); end
    tests++;
    if (d2 != 2*FR + 1) begin fails++; $display("FAIL b2b_done2: at %0d want %0d", d2, 2*FR + 1); end
    tests++;
    if (tx_s[FR+1] !== 1'b0 || busy_s[FR+1] !== 1'b1) begin
      fails++;
      $display("FAIL b2b_restart: tx=%b busy=%b want 0 1", tx_s[FR+1], busy_s[FR+1]);
    end
    bad = 0;
    for (int i = 0; i < FR; i++) if (tx_s[i] !== exp_bit(8'h01, i / CC)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL b2b_frame1: %0d cycles wrong, want 0", bad); end
    bad = 0;
    for (int i = 0; i < FR; i++) if (tx_s[FR + 1 + i] !== exp_bit(8'h80, i / CC)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL b2b_frame2: %0d cycles wrong, want 0", bad); end
  endtask

  task automatic test_reset_midframe;
    int bad, nd;
    start_frame(8'hF0);
    capture(FR + 5, -1, 8'h00, 500);
    tests++;
    if (tx_s[501] !== 1'b1 || busy_s[501] !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_abort: tx=%b busy=%b want 1 0", tx_s[501], busy_s[501]);
    end
    bad = 0; nd = 0;
    for (int i = 501; i < FR + 5; i++) begin
      if (tx_s[i] !== 1'b1 || busy_s[i] !== 1'b0) bad++;
      if (done_s[i] !== 1'b0) nd++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL rstmid_idle: %0d cycles not idle, want 0", bad); end
    tests++;
    if (nd != 0) begin fails++; $display("FAIL rstmid_done: %0d done cycles, want 0", nd); end
    start_frame(8'h3C);
    capture(FR + 5, -1, 8'h00, -1);
    bad = 0;
    for (int i = 0; i < FR; i++) if (tx_s[i] !== exp_bit(8'h3C, i / CC)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL rstmid_3c_frame: %0d cycles wrong, want 0", bad); end
    tests++;
    if (done_s[FR] !== 1'b1) begin fails++; $display("FAIL rstmid_3c_done: got %b want 1", done_s[FR]); end
  endtask

  initial begin
    bus.newd    = 1'b0;
    bus.tx_data = 8'h00;
    test_reset();
    test_idle();
    test_frame_55();
    test_loopback_a3();
    test_ignore_busy();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
